fifo: RTL and testbench

//   Synchronous single-clock FIFO buffer with valid/ready-style push/pop strobes.

---
 rtl/fifo.sv | 66 ++++++
 tb/tb_fifo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty flags.
// DEPTH may be any integer >= 1; pointers wrap explicitly rather than by overflow.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w_valid,
  input  logic             r_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             fifo_full,
  output logic             fifo_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Handshake: a push transfers on any rising edge where w_valid=1 and fifo_full=0;
  // a pop transfers where r_ready=1 and fifo_empty=0. Both use the flags as they stood
  // before the edge, so a full FIFO never accepts a write even while it is being read.
  assign fifo_full  = (r_count == FULL_CNT);
  assign fifo_empty = (r_count == '0);
  assign w_push     = w_valid && !fifo_full;
  assign w_pop      = r_ready && !fifo_empty;
  assign data_out   = fifo_empty ? '0 : r_mem[r_rd_ptr];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_in;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Bench for fifo at WIDTH=32, DEPTH=3: table-driven vectors with a queue scoreboard,
// hand-written reset sequences and a random burst.
module tb_fifo;

  localparam int W = 32;
  localparam int D = 3;

  logic         clk;
  logic         reset;
  logic         w_valid;
  logic         r_ready;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic         fifo_full;
  logic         fifo_empty;

  fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .w_valid    (w_valid),
    .r_ready    (r_ready),
    .data_in    (data_in),
    .data_out   (data_out),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Drives one cycle of strobes, checks pre-edge outputs against the queue model,
  // then lets the edge happen and updates the model.
  task automatic do_cycle(input logic wv, input logic rr, input logic [W-1:0] din);
    bit push_ok;
    bit pop_ok;
    @(negedge clk);
    w_valid = wv;
    r_ready = rr;
    data_in = din;
    #1;
    check("sb_full",  W'(fifo_full),  W'(exp_q.size() == D));
    check("sb_empty", W'(fifo_empty), W'(exp_q.size() == 0));
    push_ok = wv && (exp_q.size() < D);
    pop_ok  = rr && (exp_q.size() > 0);
    if (exp_q.size() == 0) check("sb_dout_idle", data_out, '0);
    else if (pop_ok)       check("sb_pop_data", data_out, exp_q.pop_front());
    else                   check("sb_head", data_out, exp_q[0]);
    if (push_ok) exp_q.push_back(din);
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    r_ready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         wv;
    logic         rr;
    logic [W-1:0] din;
    logic         e_full;
    logic         e_empty;
    logic [W-1:0] e_dout;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic wv, input logic rr, input logic [W-1:0] din,
                              input logic f, input logic e, input logic [W-1:0] dout);
    vec_t v;
    v.wv = wv; v.rr = rr; v.din = din; v.e_full = f; v.e_empty = e; v.e_dout = dout;
    return v;
  endfunction

  initial begin
    // fill, overflow, drain, pop-on-empty, push+pop on empty
    vecs[0]  = mk(1, 0, 32'd0,  0, 0, 32'd0);
    vecs[1]  = mk(1, 0, 32'd1,  0, 0, 32'd0);
    vecs[2]  = mk(1, 0, 32'd2,  1, 0, 32'd0);
    vecs[3]  = mk(1, 0, 32'd3,  1, 0, 32'd0);
    vecs[4]  = mk(0, 1, 32'd0,  0, 0, 32'd1);
    vecs[5]  = mk(0, 1, 32'd0,  0, 0, 32'd2);
    vecs[6]  = mk(0, 1, 32'd0,  0, 1, 32'd0);
    vecs[7]  = mk(0, 1, 32'd0,  0, 1, 32'd0);
    vecs[8]  = mk(1, 1, 32'd7,  0, 0, 32'd7);
    vecs[9]  = mk(0, 1, 32'd0,  0, 1, 32'd0);
    // two entries, then concurrent push+pop across pointer wrap
    vecs[10] = mk(1, 0, 32'd20, 0, 0, 32'd20);
    vecs[11] = mk(1, 0, 32'd21, 0, 0, 32'd20);
    vecs[12] = mk(1, 1, 32'd10, 0, 0, 32'd21);
    vecs[13] = mk(1, 1, 32'd11, 0, 0, 32'd10);
    vecs[14] = mk(1, 1, 32'd12, 0, 0, 32'd11);
    vecs[15] = mk(1, 1, 32'd13, 0, 0, 32'd12);
    vecs[16] = mk(1, 1, 32'd14, 0, 0, 32'd13);
    vecs[17] = mk(1, 0, 32'd15, 1, 0, 32'd13);
    // push+pop while full: only the pop lands, 16 is dropped
    vecs[18] = mk(1, 1, 32'd16, 0, 0, 32'd14);
    vecs[19] = mk(0, 1, 32'd0,  0, 0, 32'd15);
    vecs[20] = mk(0, 1, 32'd0,  0, 1, 32'd0);
  end

  // ---------------- test sequence ----------------
  initial begin
    reset   = 1'b0;
    w_valid = 1'b0;
    r_ready = 1'b0;
    data_in = '0;

    // reset state, during and after release
    repeat (2) @(negedge clk);
    check("rst_empty", W'(fifo_empty), W'(1));
    check("rst_full",  W'(fifo_full),  W'(0));
    check("rst_dout",  data_out,       '0);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_empty", W'(fifo_empty), W'(1));
    check("post_rst_full",  W'(fifo_full),  W'(0));
    check("post_rst_dout",  data_out,       '0);

    for (int i = 0; i < NV; i++) begin
      do_cycle(vecs[i].wv, vecs[i].rr, vecs[i].din);
      check($sformatf("vec%0d_full", i),  W'(fifo_full),  W'(vecs[i].e_full));
      check($sformatf("vec%0d_empty", i), W'(fifo_empty), W'(vecs[i].e_empty));
      check($sformatf("vec%0d_dout", i),  data_out,       vecs[i].e_dout);
    end

    // mid-operation reset with two entries: flags must clear without a clock edge
    do_cycle(1, 0, 32'h11);
    do_cycle(1, 0, 32'h22);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_empty", W'(fifo_empty), W'(1));
    check("midrst_full",  W'(fifo_full),  W'(0));
    check("midrst_dout",  data_out,       '0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    do_cycle(1, 0, 32'hA5A5A5A5);
    do_cycle(1, 0, 32'h5A5A5A5A);
    check("midrst_first", data_out, 32'hA5A5A5A5);
    do_cycle(0, 1, '0);
    do_cycle(0, 1, '0);

    // reset while full
    for (int i = 0; i < D; i++) do_cycle(1, 0, W'(32'h100 + i));
    check("full_before_rst", W'(fifo_full), W'(1));
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("fullrst_full",  W'(fifo_full),  W'(0));
    check("fullrst_empty", W'(fifo_empty), W'(1));
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;

    // random burst against the queue model
    for (int i = 0; i < 300; i++) begin
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), W'($urandom));
    end
    while (exp_q.size() > 0) do_cycle(0, 1, '0);
    check("final_empty", W'(fifo_empty), W'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
